// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard sequencer: state encoding,
// register index width and the control bundle driven onto the stage registers.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_MWAIT = 2'd2
  } state_e;

  localparam int          REG_W   = 5;
  localparam logic [2:0]  RW_NONE = 3'b000;

  // en/clr bit order: [3]=IF/ID, [2]=ID/EX, [1]=EX/ME, [0]=ME/WB
  typedef struct packed {
    logic       pc_en;
    logic [3:0] en;
    logic [3:0] clr;
    logic       dmem_req;
  } ctl_t;

  function automatic ctl_t ctl_make(input logic pc_en, input logic [3:0] en,
                                    input logic [3:0] clr, input logic req);
    ctl_t c;
    c.pc_en    = pc_en;
    c.en       = en;
    c.clr      = clr;
    c.dmem_req = req;
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds an ID source.
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic             mem_to_reg_i,
  input  logic [2:0]       reg_write_i,
  output logic             load_use_o
);

  // x0 is never a real dependency
  assign load_use_o = mem_to_reg_i && (reg_write_i != RW_NONE) &&
                      (rd_i != '0) && ((rd_i == rs1_i) || (rd_i == rs2_i));

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer: init flush, dmem freeze with timeout, redirect flush
// and load-use bubble, plus stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 4,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs1_ID,
  input  logic [REG_W-1:0] rs2_ID,
  input  logic [REG_W-1:0] rd_EX,
  input  logic             mem_to_reg_EX,
  input  logic [2:0]       reg_write_EX,
  input  logic             redirect_EX,
  input  logic             mem_op_ME,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             en_IFID,
  output logic             en_IDEX,
  output logic             en_EXME,
  output logic             en_MEWB,
  output logic             clr_IFID,
  output logic             clr_IDEX,
  output logic             clr_EXME,
  output logic             clr_MEWB,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [3:0]       INIT_LAST = 4'(INIT_CYCLES - 1);
  localparam logic [7:0]       TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = 1;

  state_e           state_q, state_d;
  logic [3:0]       init_q, init_d;
  logic [7:0]       tcnt_q, tcnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             load_use, tmo_hit, freeze;
  ctl_t             ctl;

  hazard_detect u_detect (
    .rs1_i        (rs1_ID),
    .rs2_i        (rs2_ID),
    .rd_i         (rd_EX),
    .mem_to_reg_i (mem_to_reg_EX),
    .reg_write_i  (reg_write_EX),
    .load_use_o   (load_use)
  );

  // The last MWAIT cycle stops freezing so the pipeline advances on timeout
  assign tmo_hit = (state_q == ST_MWAIT) && (tcnt_q == TMO_LAST);
  assign freeze  = mem_op_ME && !dmem_ready && !tmo_hit;

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    stall_d = stall_q;
    flush_d = flush_q;
    ctl     = ctl_make(1'b1, 4'b1111, 4'b0000, 1'b0);
    case (state_q)
      ST_INIT: begin
        ctl    = ctl_make(1'b1, 4'b1111, 4'b1111, 1'b0);
        init_d = init_q + 4'd1;
        if (init_q == INIT_LAST) state_d = ST_RUN;
      end
      default: begin
        ctl.dmem_req = mem_op_ME;
        if (freeze) begin
          ctl.pc_en = 1'b0;
          ctl.en    = 4'b0000;
          stall_d   = stall_q + CNT_ONE;
          if (state_q == ST_RUN) begin
            state_d = ST_MWAIT;
            tcnt_d  = '0;
          end else begin
            tcnt_d  = tcnt_q + 8'd1;
          end
        end else begin
          state_d = ST_RUN;
          if (tmo_hit && mem_op_ME && !dmem_ready) err_d = 1'b1;
          if (redirect_EX) begin
            ctl.clr = 4'b1100;
            flush_d = flush_q + CNT_ONE;
          end else if (load_use) begin
            ctl.pc_en = 1'b0;
            ctl.en    = 4'b0111;
            ctl.clr   = 4'b0100;
            stall_d   = stall_q + CNT_ONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      init_q  <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign pc_en     = ctl.pc_en;
  assign en_IFID   = ctl.en[3];
  assign en_IDEX   = ctl.en[2];
  assign en_EXME   = ctl.en[1];
  assign en_MEWB   = ctl.en[0];
  assign clr_IFID  = ctl.clr[3];
  assign clr_IDEX  = ctl.clr[2];
  assign clr_EXME  = ctl.clr[1];
  assign clr_MEWB  = ctl.clr[0];
  assign dmem_req  = ctl.dmem_req;
  assign mem_err   = err_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: driver pushes hand-computed
// expectations, a negedge monitor pops and compares against the DUT.
module tb_hazard_ctrl;

  // {pc_en, en_IFID, en_IDEX, en_EXME, en_MEWB, clr_IFID, clr_IDEX, clr_EXME, clr_MEWB, dmem_req}
  localparam logic [9:0] E_INIT = 10'b1_1111_1111_0;
  localparam logic [9:0] E_NORM = 10'b1_1111_0000_0;
  localparam logic [9:0] E_NREQ = 10'b1_1111_0000_1;
  localparam logic [9:0] E_LU   = 10'b0_0111_0100_0;
  localparam logic [9:0] E_LUR  = 10'b0_0111_0100_1;
  localparam logic [9:0] E_RED  = 10'b1_1111_1100_0;
  localparam logic [9:0] E_REDR = 10'b1_1111_1100_1;
  localparam logic [9:0] E_FRZ  = 10'b0_0000_0000_1;

  typedef struct {
    logic [9:0]  ctl;
    logic        err;
    logic [31:0] stall;
    logic [31:0] flush;
    int          id;
  } exp_t;

  logic        clk, rst_n;
  logic [4:0]  rs1_ID, rs2_ID, rd_EX;
  logic        mem_to_reg_EX, redirect_EX, mem_op_ME, dmem_ready;
  logic [2:0]  reg_write_EX;
  logic        pc_en, en_IFID, en_IDEX, en_EXME, en_MEWB;
  logic        clr_IFID, clr_IDEX, clr_EXME, clr_MEWB, dmem_req, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  exp_t q[$];
  int   n_chk, n_err, vec_id;

  hazard_ctrl #(.INIT_CYCLES(4), .TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_EX(rd_EX),
    .mem_to_reg_EX(mem_to_reg_EX), .reg_write_EX(reg_write_EX),
    .redirect_EX(redirect_EX), .mem_op_ME(mem_op_ME), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .en_IFID(en_IFID), .en_IDEX(en_IDEX), .en_EXME(en_EXME),
    .en_MEWB(en_MEWB), .clr_IFID(clr_IFID), .clr_IDEX(clr_IDEX),
    .clr_EXME(clr_EXME), .clr_MEWB(clr_MEWB), .dmem_req(dmem_req),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are combinational, so every cycle carries one response
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [9:0] act;
      e   = q.pop_front();
      act = {pc_en, en_IFID, en_IDEX, en_EXME, en_MEWB,
             clr_IFID, clr_IDEX, clr_EXME, clr_MEWB, dmem_req};
      n_chk = n_chk + 4;
      if (act !== e.ctl) begin
        n_err = n_err + 1;
        $display("FAIL ctl vec%0d: got %b want %b", e.id, act, e.ctl);
      end
      if (mem_err !== e.err) begin
        n_err = n_err + 1;
        $display("FAIL mem_err vec%0d: got %b want %b", e.id, mem_err, e.err);
      end
      if (stall_cnt !== e.stall) begin
        n_err = n_err + 1;
        $display("FAIL stall_cnt vec%0d: got %0d want %0d", e.id, stall_cnt, e.stall);
      end
      if (flush_cnt !== e.flush) begin
        n_err = n_err + 1;
        $display("FAIL flush_cnt vec%0d: got %0d want %0d", e.id, flush_cnt, e.flush);
      end
    end
  end

  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic m2r, input logic [2:0] rw, input logic red,
                      input logic mop, input logic rdy, input logic [9:0] ectl,
                      input logic eerr, input int est, input int efl);
    exp_t e;
    rs1_ID = rs1; rs2_ID = rs2; rd_EX = rd; mem_to_reg_EX = m2r;
    reg_write_EX = rw; redirect_EX = red; mem_op_ME = mop; dmem_ready = rdy;
    e.ctl = ectl; e.err = eerr; e.stall = est; e.flush = efl; e.id = vec_id;
    vec_id = vec_id + 1;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic [9:0] ectl, input logic eerr, input int est, input int efl);
    step(5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, ectl, eerr, est, efl);
  endtask

  initial begin
    n_chk = 0; n_err = 0; vec_id = 0;
    rst_n = 1'b0;
    rs1_ID = '0; rs2_ID = '0; rd_EX = '0; mem_to_reg_EX = 1'b0;
    reg_write_EX = '0; redirect_EX = 1'b0; mem_op_ME = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); #1;
    // reset held: INIT outputs even with a memory op pending
    step(5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, E_INIT, 1'b0, 0, 0);
    idle(E_INIT, 1'b0, 0, 0);
    rst_n = 1'b1;
    // exactly 4 INIT cycles, then RUN
    for (int i = 0; i < 4; i++) idle(E_INIT, 1'b0, 0, 0);
    idle(E_NORM, 1'b0, 0, 0);
    // load-use on rs2, then bubble in EX
    step(5'd1, 5'd5, 5'd5, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, E_LU, 1'b0, 0, 0);
    step(5'd1, 5'd5, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, E_NORM, 1'b0, 1, 0);
    // rd_EX = 0 and reg_write = 0 never stall
    step(5'd0, 5'd0, 5'd0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, E_NORM, 1'b0, 1, 0);
    step(5'd7, 5'd2, 5'd7, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, E_NORM, 1'b0, 1, 0);
    // load-use on rs1
    step(5'd7, 5'd2, 5'd7, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, E_LU, 1'b0, 1, 0);
    idle(E_NORM, 1'b0, 2, 0);
    // redirect wins over load-use
    step(5'd1, 5'd5, 5'd5, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, E_RED, 1'b0, 2, 0);
    idle(E_NORM, 1'b0, 2, 1);
    // dmem freeze: ready on 3rd cycle, redirect ignored until release
    step(5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, E_FRZ, 1'b0, 2, 1);
    step(5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, E_FRZ, 1'b0, 3, 1);
    step(5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, E_REDR, 1'b0, 4, 1);
    idle(E_NORM, 1'b0, 4, 2);
    // release cycle applies load-use
    step(5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, E_FRZ, 1'b0, 4, 2);
    step(5'd3, 5'd0, 5'd3, 1'b1, 3'd1, 1'b0, 1'b1, 1'b1, E_LUR, 1'b0, 5, 2);
    idle(E_NORM, 1'b0, 6, 2);
    // timeout: 16 frozen cycles, then forced advance and sticky mem_err
    for (int i = 0; i < 16; i++)
      step(5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, E_FRZ, 1'b0, 6 + i, 2);
    step(5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, E_NREQ, 1'b0, 22, 2);
    idle(E_NORM, 1'b1, 22, 2);
    idle(E_NORM, 1'b1, 22, 2);
    // reset in the 2nd MWAIT cycle abandons the access
    step(5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, E_FRZ, 1'b1, 22, 2);
    step(5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, E_FRZ, 1'b1, 23, 2);
    rst_n = 1'b0;
    step(5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, E_INIT, 1'b0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle(E_INIT, 1'b0, 0, 0);
    idle(E_NORM, 1'b0, 0, 0);
    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    n_chk = n_chk + 1;
    if (q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL drain: %0d responses left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
